mac_out_drain: RTL and testbench
================================

Name: mac_out_drain

Overview:
- Downstream stage of the quad MAC cluster.
- On a capture strobe, snapshots the four MAC_ACC_WIDTH accumulator outputs, then serialises the lanes valid for the current mode onto a narrow valid/ready stream, LSB beat first.
- Lets the cluster keep accumulating while results drain to the fabric or an I/O bus.

Parameters:
- MAC_ACC_WIDTH, 32, width of each cluster output lane.
- OUT_WIDTH, 8, stream data width; must divide MAC_ACC_WIDTH exactly.
- BEATS, MAC_ACC_WIDTH/OUT_WIDTH, beats per lane (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- capture  in  1  snapshot request, one cycle
- mode  in  2  cluster size mode: 00 single, 01 dual, 10 quad, 11 reserved
- in0..in3  in  MAC_ACC_WIDTH each  cluster outputs out0..out3
- dout  out  OUT_WIDTH  stream data
- dout_valid  out  1  beat valid
- dout_ready  in  1  sink accept
- dout_last  out  1  final beat of the snapshot
- busy  out  1  snapshot in flight
- overrun  out  1  one-cycle pulse: capture dropped

Behaviour:
- Reset (async, active-high): state IDLE; dout=0, dout_valid=0, dout_last=0, busy=0, overrun=0; shadow registers and counters cleared.
- Reset mid-transfer aborts the snapshot. No partial beats follow reset deassertion.
- Lane count from mode, latched at capture: 00 -> 4 lanes (in0..in3); 01 -> 2 lanes (in0, in1); 10 or 11 -> 1 lane (in0).
- FSM states:
  - IDLE: capture=1 -> register in0..in3 and the lane count; lane_idx=0, beat_idx=0; go to SEND. dout_valid rises the cycle after capture, giving one-cycle latency.
  - SEND: dout = shadow[lane_idx][beat_idx*OUT_WIDTH +: OUT_WIDTH].
    - Handshake occurs when dout_valid&&dout_ready. On a handshake, beat_idx increments. At BEATS-1 it wraps to 0 and lane_idx increments.
    - dout_last=1 exactly when lane_idx=lanes-1 and beat_idx=BEATS-1.
    - A handshake on the last beat returns to IDLE.
- Valid/ready rules:
  - dout_valid never drops without a handshake.
  - dout and dout_last are stable while valid && !ready.
  - The sink may hold ready high permanently, giving one beat per cycle.
- busy=1 in SEND.
- Capture while in SEND, except on the last-beat handshake cycle: ignored. Shadow registers are untouched and overrun pulses for one cycle the next cycle.
- Capture on the same cycle as the last-beat handshake: accepted as a new snapshot. Stay in SEND, counters reset to 0, new data on the next cycle, dout_valid stays high, no overrun.
- mode changes during SEND have no effect on the snapshot in flight.
- Total beats per snapshot = lanes*BEATS: 16/8/4 for the defaults.

Optional Feature:
- MAC_DRAIN_PARITY_EN defined: adds output dout_parity (1 bit) = XOR of dout bits (even parity over dout plus parity bit). Registered with dout and stable under the same rules; 0 after reset.
- Undefined: no dout_parity port and no parity logic.

Decomposition:
- Mode encodings (single/dual/quad/reserved) and their lane counts live as `define constants in mac_const.vh, shared with the cluster and combiner.
- FSM state encodings stay local to the block.
- One natural sub-module: mac_drain_lane_mux. It is combinational and selects lane_idx/beat_idx from the four shadow registers, keeping the FSM file small.

Test Plan:
- Single mode, ready=1: in0=0x04030201, in1=0x08070605, in2=0x0C0B0A09, in3=0x100F0E0D, capture -> dout 0x01..0x10 on 16 consecutive cycles starting one cycle after capture; dout_last only on 0x10; busy then falls.
- Dual mode with backpressure: in0=0xDEADBEEF, in1=0xCAFEF00D, ready toggling 1,0,1,0 -> beats EF,BE,AD,DE,0D,F0,FE,CA; values held stable while ready=0; exactly 8 handshakes.
- Quad mode: in0=0x12345678, in1..in3 nonzero -> only 78,56,34,12 emitted; last on 12.
- Overrun: capture in quad mode, then capture on beat 1 -> overrun pulse one cycle later; original 4 beats unchanged. Capture coincident with last-beat handshake -> no overrun, new snapshot streams back-to-back with no valid gap.
- Reset mid-transfer: assert rst asynchronously after beat 2 of single mode -> all outputs 0 immediately; after deassert, no beats until the next capture.
- MAC_DRAIN_PARITY_EN: dout=0x07 -> dout_parity=1; dout=0x03 -> 0; port absent when the macro is undefined (compile check).

Source files
------------

// File: rtl/mac_out_drain_pkg.sv
// Shared constants and helpers for the MAC output drain.
// Mode encodings and lane counts mirror the cluster-wide mac_const definitions.
`ifndef MAC_CONST_VH
`define MAC_CONST_VH
`define MAC_MODE_SINGLE   2'b00
`define MAC_MODE_DUAL     2'b01
`define MAC_MODE_QUAD     2'b10
`define MAC_MODE_RSVD     2'b11
`define MAC_LANES_SINGLE  4
`define MAC_LANES_DUAL    2
`define MAC_LANES_QUAD    1
`endif

package mac_out_drain_pkg;

  localparam int unsigned MAC_ACC_WIDTH_DEF = 32;
  localparam int unsigned OUT_WIDTH_DEF     = 8;

  // Index of the final lane to drain for a given cluster mode.
  function automatic logic [1:0] lane_last_from_mode(input logic [1:0] mode);
    logic [1:0] r;
    case (mode)
      `MAC_MODE_SINGLE: r = 2'(`MAC_LANES_SINGLE - 1);
      `MAC_MODE_DUAL:   r = 2'(`MAC_LANES_DUAL - 1);
      default:          r = 2'(`MAC_LANES_QUAD - 1);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mac_drain_lane_mux.sv
// Combinational beat selector: picks one OUT_W slice of one of four lanes.
module mac_drain_lane_mux #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned BEAT_W = 2
) (
  input  logic [ACC_W-1:0]  lane0,
  input  logic [ACC_W-1:0]  lane1,
  input  logic [ACC_W-1:0]  lane2,
  input  logic [ACC_W-1:0]  lane3,
  input  logic [1:0]        lane_idx,
  input  logic [BEAT_W-1:0] beat_idx,
  output logic [OUT_W-1:0]  data
);

  logic [ACC_W-1:0] sel;
  int unsigned      base;

  always_comb begin
    sel = '0;
    case (lane_idx)
      2'd0: sel = lane0;
      2'd1: sel = lane1;
      2'd2: sel = lane2;
      default: sel = lane3;
    endcase
    base = 32'(beat_idx) * OUT_W;
    data = sel[base +: OUT_W];
  end

endmodule

// File: rtl/mac_out_drain.sv
// Snapshots four MAC accumulators and drains the active lanes LSB-first on a valid/ready stream.
// Optional dout_parity output when MAC_DRAIN_PARITY_EN is defined.
module mac_out_drain
  import mac_out_drain_pkg::*;
#(
  parameter int unsigned MAC_ACC_WIDTH = MAC_ACC_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH     = OUT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic [1:0]               mode,
  input  logic [MAC_ACC_WIDTH-1:0] in0,
  input  logic [MAC_ACC_WIDTH-1:0] in1,
  input  logic [MAC_ACC_WIDTH-1:0] in2,
  input  logic [MAC_ACC_WIDTH-1:0] in3,
  output logic [OUT_WIDTH-1:0]     dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_last,
`ifdef MAC_DRAIN_PARITY_EN
  output logic                     dout_parity,
`endif
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned BEATS  = MAC_ACC_WIDTH / OUT_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state, nxt_state;
  logic [MAC_ACC_WIDTH-1:0] sh0, sh1, sh2, sh3;
  logic [1:0]               lane_idx, nxt_lane;
  logic [1:0]               lane_last_q, nxt_lane_last;
  logic [BEAT_W-1:0]        beat_idx, nxt_beat;
  logic                     hs, last_hs, accept, nxt_last;
  logic [MAC_ACC_WIDTH-1:0] src0, src1, src2, src3;
  logic [OUT_WIDTH-1:0]     mux_data;

  // Outputs are registered from the next-cycle indices, so on an accepted
  // capture the mux reads the live inputs rather than the not-yet-loaded shadows.
  always_comb begin
    hs            = dout_valid && dout_ready;
    last_hs       = hs && dout_last;
    accept        = capture && ((state == IDLE) || last_hs);
    nxt_state     = state;
    nxt_lane      = lane_idx;
    nxt_beat      = beat_idx;
    nxt_lane_last = lane_last_q;
    if (accept) begin
      nxt_state     = SEND;
      nxt_lane      = '0;
      nxt_beat      = '0;
      nxt_lane_last = lane_last_from_mode(mode);
    end else if (last_hs) begin
      nxt_state = IDLE;
      nxt_lane  = '0;
      nxt_beat  = '0;
    end else if (hs) begin
      if (beat_idx == BEAT_LAST) begin
        nxt_beat = '0;
        nxt_lane = lane_idx + 2'd1;
      end else begin
        nxt_beat = beat_idx + 1'b1;
      end
    end
    src0     = accept ? in0 : sh0;
    src1     = accept ? in1 : sh1;
    src2     = accept ? in2 : sh2;
    src3     = accept ? in3 : sh3;
    nxt_last = (nxt_lane == nxt_lane_last) && (nxt_beat == BEAT_LAST);
  end

  mac_drain_lane_mux #(
    .ACC_W  (MAC_ACC_WIDTH),
    .OUT_W  (OUT_WIDTH),
    .BEAT_W (BEAT_W)
  ) u_lane_mux (
    .lane0    (src0),
    .lane1    (src1),
    .lane2    (src2),
    .lane3    (src3),
    .lane_idx (nxt_lane),
    .beat_idx (nxt_beat),
    .data     (mux_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      sh3         <= '0;
      lane_idx    <= '0;
      beat_idx    <= '0;
      lane_last_q <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      dout_last   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
`ifdef MAC_DRAIN_PARITY_EN
      dout_parity <= 1'b0;
`endif
    end else begin
      state       <= nxt_state;
      lane_idx    <= nxt_lane;
      beat_idx    <= nxt_beat;
      lane_last_q <= nxt_lane_last;
      if (accept) begin
        sh0 <= in0;
        sh1 <= in1;
        sh2 <= in2;
        sh3 <= in3;
      end
      dout_valid <= (nxt_state == SEND);
      busy       <= (nxt_state == SEND);
      dout       <= (nxt_state == SEND) ? mux_data : '0;
      dout_last  <= (nxt_state == SEND) && nxt_last;
      overrun    <= capture && (state == SEND) && !last_hs;
`ifdef MAC_DRAIN_PARITY_EN
      dout_parity <= (nxt_state == SEND) ? ^mux_data : 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mac_out_drain.sv
// Directed self-checking bench for mac_out_drain (default 32-bit lanes, 8-bit stream).
module tb_mac_out_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture;
  logic [1:0]  mode;
  logic [31:0] in0, in1, in2, in3;
  logic [7:0]  dout;
  logic        dout_valid, dout_ready, dout_last, busy, overrun;
`ifdef MAC_DRAIN_PARITY_EN
  logic        dout_parity;
`endif

  int checks = 0;
  int errors = 0;

  mac_out_drain #(.MAC_ACC_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .mode       (mode),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
`ifdef MAC_DRAIN_PARITY_EN
    .dout_parity(dout_parity),
`endif
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_dout"},  32'(dout),       32'd0);
    check({tag, "_last"},  32'(dout_last),  32'd0);
  endtask

  logic [7:0] exp_dual [8];
  logic [7:0] exp_q2   [8];

  initial begin
    exp_dual = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    exp_q2   = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    rst = 1'b1; capture = 1'b0; mode = 2'b00; dout_ready = 1'b1;
    in0 = 32'h04030201; in1 = 32'h08070605; in2 = 32'h0C0B0A09; in3 = 32'h100F0E0D;
    #3;
    check_idle("reset");
    check("reset_overrun", 32'(overrun), 32'd0);
    #20 rst = 1'b0;
    step();
    check_idle("post_reset");

    // Four-lane mode, sink always ready
    capture = 1'b1; step(); capture = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("m0_valid", 32'(dout_valid), 32'd1);
      check("m0_dout",  32'(dout),       32'(i + 1));
      check("m0_last",  32'(dout_last),  32'(i == 15));
      check("m0_busy",  32'(busy),       32'd1);
`ifdef MAC_DRAIN_PARITY_EN
      if (i == 6) check("par_07", 32'(dout_parity), 32'd1);
      if (i == 2) check("par_03", 32'(dout_parity), 32'd0);
`endif
      step();
    end
    check_idle("m0_done");

    // Two-lane mode with backpressure; mode change mid-flight is ignored
    mode = 2'b01; in0 = 32'hDEADBEEF; in1 = 32'hCAFEF00D; in2 = 32'h11111111; in3 = 32'h22222222;
    capture = 1'b1; step(); capture = 1'b0; mode = 2'b00;
    for (int k = 0; k < 8; k++) begin
      dout_ready = 1'b0;
      check("m1_dout",  32'(dout), 32'(exp_dual[k]));
      step();
      check("m1_hold",  32'(dout),       32'(exp_dual[k]));
      check("m1_valid", 32'(dout_valid), 32'd1);
      check("m1_last",  32'(dout_last),  32'(k == 7));
      dout_ready = 1'b1;
      step();
    end
    check_idle("m1_done");
    dout_ready = 1'b1;

    // Single-lane mode: only in0 drains
    mode = 2'b10; in0 = 32'h12345678; in1 = 32'hAAAAAAAA; in2 = 32'hBBBBBBBB; in3 = 32'hCCCCCCCC;
    capture = 1'b1; step(); capture = 1'b0;
    check("m2_b0", 32'(dout), 32'h78); check("m2_l0", 32'(dout_last), 32'd0); step();
    check("m2_b1", 32'(dout), 32'h56); step();
    check("m2_b2", 32'(dout), 32'h34); step();
    check("m2_b3", 32'(dout), 32'h12); check("m2_l3", 32'(dout_last), 32'd1); step();
    check_idle("m2_done");

    // Overrun on mid-transfer capture, then back-to-back capture on last beat
    in0 = 32'hA1B2C3D4;
    capture = 1'b1; step(); capture = 1'b0;
    check("ov_b0", 32'(dout), 32'hD4); step();
    check("ov_b1", 32'(dout), 32'hC3);
    in0 = 32'h55667788; capture = 1'b1; step(); capture = 1'b0;
    check("ov_pulse", 32'(overrun), 32'd1);
    check("ov_b2",    32'(dout),    32'hB2); step();
    check("ov_clear", 32'(overrun), 32'd0);
    check("ov_b3",    32'(dout),    32'hA1);
    check("ov_l3",    32'(dout_last), 32'd1);
    mode = 2'b01; in0 = 32'h11223344; in1 = 32'h55667788;
    capture = 1'b1; step(); capture = 1'b0;
    check("b2b_valid",   32'(dout_valid), 32'd1);
    check("b2b_overrun", 32'(overrun),    32'd0);
    check("b2b_busy",    32'(busy),       32'd1);
    for (int k = 0; k < 8; k++) begin
      check("b2b_dout",  32'(dout),       32'(exp_q2[k]));
      check("b2b_valid", 32'(dout_valid), 32'd1);
      check("b2b_last",  32'(dout_last),  32'(k == 7));
      step();
    end
    check_idle("b2b_done");

    // Asynchronous reset mid-transfer
    mode = 2'b00; in0 = 32'h04030201; in1 = 32'h08070605;
    capture = 1'b1; step(); capture = 1'b0;
    step(); step();
    check("rst_pre", 32'(dout), 32'h03);
    #2 rst = 1'b1;
    #1;
    check_idle("rst_async");
    check("rst_overrun", 32'(overrun), 32'd0);
    #13 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_quiet_valid", 32'(dout_valid), 32'd0);
      check("rst_quiet_busy",  32'(busy),       32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
